// File: rtl/lsu_dmem_port.sv
// Load/store requester for one port of the byte-enabled, synchronous-read data memory.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (misaligned/reserved-size requests flagged as errors).
module lsu_dmem_port #(
    parameter int ADDR_W = 16
) (
    input  logic              i_clk,
    input  logic              i_reset,
    input  logic              i_req_valid,
    output logic              o_req_ready,
    input  logic              i_req_we,
    input  logic [ADDR_W-1:0] i_req_addr,
    input  logic [1:0]        i_req_size,
    input  logic              i_req_unsigned,
    input  logic [31:0]       i_req_wdata,
    output logic              o_rsp_valid,
    input  logic              i_rsp_ready,
    output logic [31:0]       o_rsp_rdata,
    output logic              o_rsp_err,
    output logic [ADDR_W-3:0] o_mem_addr,
    output logic [31:0]       o_mem_data,
    output logic [3:0]        o_mem_wren,
    input  logic [31:0]       i_mem_q
);

    typedef enum logic [1:0] {IDLE, RD_WAIT, RESP} state_t;

    state_t      state_reg, state_next;
    logic [1:0]  lane_reg, lane_next;
    logic [1:0]  size_reg, size_next;
    logic        unsigned_reg, unsigned_next;
    logic        rsp_valid_reg, rsp_valid_next;
    logic [31:0] rsp_rdata_reg, rsp_rdata_next;
    logic        rsp_err_reg, rsp_err_next;

    logic        accept;
    logic        misalign;
    logic [3:0]  wren_mask;
    logic [31:0] load_data;
    logic [7:0]  load_byte;
    logic [15:0] load_half;

    assign accept      = i_req_valid && (state_reg == IDLE);
    assign o_req_ready = (state_reg == IDLE);
    assign o_mem_addr  = i_req_addr[ADDR_W-1:2];

`ifdef LSU_MISALIGN_TRAP_EN
    always_comb begin
        misalign = 1'b0;
        case (i_req_size)
            2'b00:   misalign = 1'b0;
            2'b01:   misalign = i_req_addr[0];
            2'b10:   misalign = (i_req_addr[1:0] != 2'b00);
            default: misalign = 1'b1;
        endcase
    end
`else
    assign misalign = 1'b0;
`endif

    // Store data lanes: byte replicated x4, half replicated x2, word passed through.
    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_wlane
            always_comb begin
                o_mem_data[8*gi +: 8] = i_req_wdata[8*gi +: 8];
                if (i_req_size == 2'b00)
                    o_mem_data[8*gi +: 8] = i_req_wdata[7:0];
                else if (i_req_size == 2'b01)
                    o_mem_data[8*gi +: 8] = i_req_wdata[8*(gi%2) +: 8];
            end
        end
    endgenerate

    always_comb begin
        wren_mask = 4'b1111;
        case (i_req_size)
            2'b00:   wren_mask = 4'b0001 << i_req_addr[1:0];
            2'b01:   wren_mask = 4'b0011 << {i_req_addr[1], 1'b0};
            default: wren_mask = 4'b1111;
        endcase
        o_mem_wren = (accept && i_req_we && !misalign) ? wren_mask : 4'b0000;
    end

    // Lane selection uses the request fields latched at accept, not the live inputs.
    always_comb begin
        load_byte = i_mem_q[8*lane_reg +: 8];
        load_half = i_mem_q[16*lane_reg[1] +: 16];
        case (size_reg)
            2'b00:   load_data = {{24{load_byte[7] & ~unsigned_reg}}, load_byte};
            2'b01:   load_data = {{16{load_half[15] & ~unsigned_reg}}, load_half};
            default: load_data = i_mem_q;
        endcase
    end

    always_comb begin
        state_next     = state_reg;
        lane_next      = lane_reg;
        size_next      = size_reg;
        unsigned_next  = unsigned_reg;
        rsp_valid_next = rsp_valid_reg;
        rsp_rdata_next = rsp_rdata_reg;
        rsp_err_next   = rsp_err_reg;
        case (state_reg)
            IDLE: begin
                if (accept) begin
                    lane_next      = i_req_addr[1:0];
                    size_next      = i_req_size;
                    unsigned_next  = i_req_unsigned;
                    rsp_rdata_next = 32'h0;
                    rsp_err_next   = misalign;
                    if (misalign || i_req_we) begin
                        state_next     = RESP;
                        rsp_valid_next = 1'b1;
                    end else begin
                        state_next = RD_WAIT;
                    end
                end
            end
            RD_WAIT: begin
                state_next     = RESP;
                rsp_valid_next = 1'b1;
                rsp_rdata_next = load_data;
            end
            RESP: begin
                if (i_rsp_ready) begin
                    state_next     = IDLE;
                    rsp_valid_next = 1'b0;
                    rsp_rdata_next = 32'h0;
                    rsp_err_next   = 1'b0;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_reg     <= IDLE;
            lane_reg      <= 2'b00;
            size_reg      <= 2'b00;
            unsigned_reg  <= 1'b0;
            rsp_valid_reg <= 1'b0;
            rsp_rdata_reg <= 32'h0;
            rsp_err_reg   <= 1'b0;
        end else begin
            state_reg     <= state_next;
            lane_reg      <= lane_next;
            size_reg      <= size_next;
            unsigned_reg  <= unsigned_next;
            rsp_valid_reg <= rsp_valid_next;
            rsp_rdata_reg <= rsp_rdata_next;
            rsp_err_reg   <= rsp_err_next;
        end
    end

    assign o_rsp_valid = rsp_valid_reg;
    assign o_rsp_rdata = rsp_rdata_reg;
`ifdef LSU_MISALIGN_TRAP_EN
    assign o_rsp_err = rsp_err_reg;
`else
    assign o_rsp_err = 1'b0;
`endif

endmodule

// File: tb/tb_lsu_dmem_port.sv
// Directed bench for lsu_dmem_port with a behavioural synchronous-read byte-enabled memory.
module tb_lsu_dmem_port;

    logic        i_clk = 1'b0;
    logic        i_reset;
    logic        i_req_valid;
    logic        o_req_ready;
    logic        i_req_we;
    logic [15:0] i_req_addr;
    logic [1:0]  i_req_size;
    logic        i_req_unsigned;
    logic [31:0] i_req_wdata;
    logic        o_rsp_valid;
    logic        i_rsp_ready;
    logic [31:0] o_rsp_rdata;
    logic        o_rsp_err;
    logic [13:0] o_mem_addr;
    logic [31:0] o_mem_data;
    logic [3:0]  o_mem_wren;
    logic [31:0] i_mem_q;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mem [0:16383];

    lsu_dmem_port #(.ADDR_W(16)) dut (
        .i_clk(i_clk), .i_reset(i_reset),
        .i_req_valid(i_req_valid), .o_req_ready(o_req_ready),
        .i_req_we(i_req_we), .i_req_addr(i_req_addr), .i_req_size(i_req_size),
        .i_req_unsigned(i_req_unsigned), .i_req_wdata(i_req_wdata),
        .o_rsp_valid(o_rsp_valid), .i_rsp_ready(i_rsp_ready),
        .o_rsp_rdata(o_rsp_rdata), .o_rsp_err(o_rsp_err),
        .o_mem_addr(o_mem_addr), .o_mem_data(o_mem_data), .o_mem_wren(o_mem_wren),
        .i_mem_q(i_mem_q)
    );

    always #5 i_clk = ~i_clk;

    always @(posedge i_clk) begin
        for (int b = 0; b < 4; b++)
            if (o_mem_wren[b]) mem[o_mem_addr][8*b +: 8] <= o_mem_data[8*b +: 8];
        i_mem_q <= mem[o_mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Issue one request starting at posedge+1 and follow it to completion.
    task automatic do_req(input string tag, input bit we, input logic [15:0] addr,
                          input logic [1:0] size, input bit uns, input logic [31:0] wdata,
                          input logic [3:0] exp_wren, input logic [31:0] exp_mdata,
                          input int exp_lat, input logic [31:0] exp_rdata, input bit exp_err,
                          input int hold);
        int n;
        logic [31:0] held;
        i_req_valid = 1'b1; i_req_we = we; i_req_addr = addr; i_req_size = size;
        i_req_unsigned = uns; i_req_wdata = wdata;
        #3;
        check({tag, ".ready"}, o_req_ready, 1);
        check({tag, ".wren"}, o_mem_wren, exp_wren);
        check({tag, ".maddr"}, o_mem_addr, addr[15:2]);
        if (exp_wren != 4'h0) check({tag, ".mdata"}, o_mem_data, exp_mdata);
        @(posedge i_clk); #1;
        // Scramble request inputs to prove fields were latched at accept.
        i_req_valid = 1'b0; i_req_addr = addr ^ 16'h0003; i_req_size = ~size;
        i_req_unsigned = ~uns; i_req_wdata = ~wdata;
        n = 1;
        while (!o_rsp_valid && n < 6) begin
            @(posedge i_clk); #1; n++;
        end
        check({tag, ".rsp_valid"}, o_rsp_valid, 1);
        check({tag, ".latency"}, n, exp_lat);
        check({tag, ".rdata"}, o_rsp_rdata, exp_rdata);
        check({tag, ".err"}, o_rsp_err, exp_err);
        held = o_rsp_rdata;
        for (int h = 0; h < hold; h++) begin
            i_req_valid = 1'b1; i_req_we = 1'b1;
            #3;
            check({tag, ".hold_wren"}, o_mem_wren, 0);
            check({tag, ".hold_ready"}, o_req_ready, 0);
            @(posedge i_clk); #1;
            check({tag, ".hold_valid"}, o_rsp_valid, 1);
            check({tag, ".hold_rdata"}, o_rsp_rdata, held);
        end
        i_req_valid = 1'b0;
        i_rsp_ready = 1'b1;
        @(posedge i_clk); #1;
        i_rsp_ready = 1'b0;
        check({tag, ".idle_ready"}, o_req_ready, 1);
        check({tag, ".idle_valid"}, o_rsp_valid, 0);
        $display("txn %s we=%0d addr=%h size=%0d rdata=%h err=%0d", tag, we, addr, size,
                 exp_rdata, exp_err);
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) mem[i] = 32'h0;
        i_reset = 1'b1; i_req_valid = 1'b0; i_req_we = 1'b0; i_req_addr = 16'h0;
        i_req_size = 2'b00; i_req_unsigned = 1'b0; i_req_wdata = 32'h0; i_rsp_ready = 1'b0;
        repeat (3) @(posedge i_clk);
        #1 i_reset = 1'b0;
        check("rst.valid", o_rsp_valid, 0);
        check("rst.rdata", o_rsp_rdata, 0);
        check("rst.err", o_rsp_err, 0);
        check("rst.wren", o_mem_wren, 0);
        check("rst.ready", o_req_ready, 1);

        do_req("sw",  1, 16'h0010, 2'b10, 0, 32'hDEADBEEF, 4'hF, 32'hDEADBEEF, 1, 32'h0, 0, 0);
        do_req("lw",  0, 16'h0010, 2'b10, 0, 32'h0, 4'h0, 32'h0, 2, 32'hDEADBEEF, 0, 0);
        do_req("lb0", 0, 16'h0010, 2'b00, 0, 32'h0, 4'h0, 32'h0, 2, 32'hFFFFFFEF, 0, 0);
        do_req("lhu0",0, 16'h0010, 2'b01, 1, 32'h0, 4'h0, 32'h0, 2, 32'h0000BEEF, 0, 0);
        do_req("sb",  1, 16'h0013, 2'b00, 0, 32'h112233A5, 4'b1000, 32'hA5A5A5A5, 1, 32'h0, 0, 0);
        do_req("lb",  0, 16'h0013, 2'b00, 0, 32'h0, 4'h0, 32'h0, 2, 32'hFFFFFFA5, 0, 0);
        do_req("lbu", 0, 16'h0013, 2'b00, 1, 32'h0, 4'h0, 32'h0, 2, 32'h000000A5, 0, 0);
        do_req("lw2", 0, 16'h0010, 2'b10, 0, 32'h0, 4'h0, 32'h0, 2, 32'hA5ADBEEF, 0, 0);
        do_req("sh",  1, 16'h0022, 2'b01, 0, 32'h00008001, 4'b1100, 32'h80018001, 1, 32'h0, 0, 0);
        do_req("lh",  0, 16'h0022, 2'b01, 0, 32'h0, 4'h0, 32'h0, 2, 32'hFFFF8001, 0, 0);
        do_req("lhu", 0, 16'h0022, 2'b01, 1, 32'h0, 4'h0, 32'h0, 2, 32'h00008001, 0, 0);
        do_req("lwhold", 0, 16'h0010, 2'b10, 0, 32'h0, 4'h0, 32'h0, 2, 32'hA5ADBEEF, 0, 3);
        do_req("sw0", 1, 16'h0000, 2'b10, 0, 32'h12345678, 4'hF, 32'h12345678, 1, 32'h0, 0, 0);
`ifdef LSU_MISALIGN_TRAP_EN
        do_req("lwmis", 0, 16'h0002, 2'b10, 0, 32'h0, 4'h0, 32'h0, 1, 32'h0, 1, 0);
        do_req("shmis", 1, 16'h0021, 2'b01, 0, 32'h0000CAFE, 4'h0, 32'h0, 1, 32'h0, 1, 0);
        do_req("lhchk", 0, 16'h0020, 2'b10, 0, 32'h0, 4'h0, 32'h0, 2, 32'h80010000, 0, 0);
`else
        do_req("lwmis", 0, 16'h0002, 2'b10, 0, 32'h0, 4'h0, 32'h0, 2, 32'h12345678, 0, 0);
        do_req("lw11",  0, 16'h0000, 2'b11, 0, 32'h0, 4'h0, 32'h0, 2, 32'h12345678, 0, 0);
`endif

        // Reset while waiting on read data.
        i_req_valid = 1'b1; i_req_we = 1'b0; i_req_addr = 16'h0010; i_req_size = 2'b10;
        @(posedge i_clk); #1;
        i_req_valid = 1'b0;
        i_reset = 1'b1;
        @(posedge i_clk); #1;
        i_reset = 1'b0;
        check("rstmid.valid", o_rsp_valid, 0);
        check("rstmid.ready", o_req_ready, 1);
        do_req("swpost", 1, 16'h0030, 2'b10, 0, 32'hCAFEF00D, 4'hF, 32'hCAFEF00D, 1, 32'h0, 0, 0);
        do_req("lwpost", 0, 16'h0030, 2'b10, 0, 32'h0, 4'h0, 32'h0, 2, 32'hCAFEF00D, 0, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
